mole_scheduler: RTL and testbench

Game sequencer for the 5-hole whack-a-mole board. It spawns pseudo-random mole patterns into the board-state register through its load/loadval interface and times each round. It ends a round early when every mole has been hit, counts score pulses, and stops after a fixed number of rounds. It sits between the start button and the board-state register; score and round count go to the display.

---
 rtl/whack_pkg.sv | 28 ++
 rtl/mole_scheduler_if.sv | 29 ++
 rtl/mole_scheduler_lfsr16.sv | 21 ++
 rtl/mole_scheduler.sv | 108 ++++++++++
 tb/tb_mole_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/whack_pkg.sv
// Shared constants, state encoding and pattern helper
// for the whack-a-mole game sequencer.
package whack_pkg;

    localparam int NUM_HOLES = 5;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [NUM_HOLES-1:0] ZERO_FALLBACK = 5'b00100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPAWN  = 3'd1,
        ACTIVE = 3'd2,
        CLEAR  = 3'd3,
        DONE   = 3'd4
    } state_e;

    // An all-empty pattern would end the round instantly,
    // so a single middle mole stands in for it.
    function automatic logic [NUM_HOLES-1:0] spawn_pattern(
        input logic [15:0] r
    );
        if (r[NUM_HOLES-1:0] == '0)
            spawn_pattern = ZERO_FALLBACK;
        else
            spawn_pattern = r[NUM_HOLES-1:0];
    endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Game sequencer bus: start/score inputs, board load
// strobe and display outputs.
interface mole_scheduler_if
    import whack_pkg::*;
#(
    parameter int SCORE_W = 8
) ();
    logic                 start;
    logic                 score_trigger;
    logic [NUM_HOLES-1:0] board_state;
    logic                 load;
    logic [NUM_HOLES-1:0] loadval;
    logic [SCORE_W-1:0]   score;
    logic [7:0]           round;
    logic                 playing;
    logic                 game_over;

    modport master (
        input  start, score_trigger, board_state,
        output load, loadval, score, round,
        output playing, game_over
    );

    modport slave (
        output start, score_trigger, board_state,
        input  load, loadval, score, round,
        input  playing, game_over
    );
endinterface

// File: rtl/mole_scheduler_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
// Maximal length, so a nonzero seed never reaches zero.
module lfsr16
    import whack_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    // Shift every cycle; feedback is the parity of the tap bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED;
        else
            q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: spawns patterns, times
// rounds, counts hits and stops after a fixed round count.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int          MOLE_CYCLES = 25_000_000,
    parameter int          GAME_ROUNDS = 30,
    parameter int          SCORE_W     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic              clk,
    input logic              rst_n,
    mole_scheduler_if.master bus
);

    localparam int TW = (MOLE_CYCLES > 2) ? $clog2(MOLE_CYCLES) : 1;

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_SPAWN  = SPAWN;
    localparam logic [2:0] S_ACTIVE = ACTIVE;
    localparam logic [2:0] S_CLEAR  = CLEAR;
    localparam logic [2:0] S_DONE   = DONE;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [7:0] LAST_RND = 8'(GAME_ROUNDS - 1);

    logic [15:0]   rnd;
    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [TW-1:0] timer;
    logic          round_end;
    logic          last_round;
    logic          restart;
    logic          scoring;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (rnd)
    );

    // Round end, restart and scoring window decode.
    always_comb begin
        round_end  = (state == S_ACTIVE) &&
                     (timer == '0 || bus.board_state == '0);
        last_round = (bus.round == LAST_RND);
        restart    = bus.start &&
                     (state == S_IDLE || state == S_DONE);
        scoring    = (state == S_SPAWN) || (state == S_ACTIVE) ||
                     (state == S_CLEAR);
    end

    // Next-state selection.
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (bus.start) nxt = S_SPAWN;
            S_SPAWN:        nxt = S_ACTIVE;
            S_ACTIVE:
                if (round_end)
                    nxt = last_round ? S_CLEAR : S_SPAWN;
            S_CLEAR:        nxt = S_DONE;
            default:        nxt = S_IDLE;
        endcase
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            bus.load      <= 1'b0;
            bus.loadval   <= '0;
            bus.score     <= '0;
            bus.round     <= '0;
            bus.playing   <= 1'b0;
            bus.game_over <= 1'b0;
        end else begin
            state       <= nxt;
            bus.load    <= 1'b0;
            bus.loadval <= '0;
            if (nxt == S_SPAWN) begin
                bus.load    <= 1'b1;
                bus.loadval <= spawn_pattern(rnd);
            end
            if (nxt == S_CLEAR)
                bus.load <= 1'b1;
            if (restart)
                bus.round <= '0;
            else if (round_end && !last_round)
                bus.round <= bus.round + 8'd1;
            if (state == S_SPAWN)
                timer <= TW'(MOLE_CYCLES - 1);
            else if (state == S_ACTIVE)
                timer <= timer - 1'b1;
            if (restart)
                bus.score <= '0;
            else if (scoring && bus.score_trigger &&
                     bus.score != SCORE_MAX)
                bus.score <= bus.score + 1'b1;
            bus.playing   <= (nxt == S_SPAWN) ||
                             (nxt == S_ACTIVE) ||
                             (nxt == S_CLEAR);
            bus.game_over <= (nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: game-level reference
// model feeding a load scoreboard plus per-cycle status checks.
module tb_mole_scheduler;

    localparam int MC = 8;
    localparam int GR = 3;
    localparam int SW = 4;
    localparam int SMAX = 15;
    localparam int NSEQ = 8192;

    typedef struct {
        int       cyc;
        logic [4:0] val;
    } ld_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trig_man = 1'b0;
    logic trig_hit;

    always #5 clk = ~clk;

    mole_scheduler_if #(.SCORE_W(SW)) bus ();

    mole_scheduler #(
        .MOLE_CYCLES (MC),
        .GAME_ROUNDS (GR),
        .SCORE_W     (SW),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.score_trigger = trig_man | trig_hit;

    int checks = 0;
    int fails = 0;
    logic [15:0] seq [NSEQ];
    ld_t expq [$];
    int ld_cyc [$];

    // reference model variables
    int cyc = 0;
    int phase = 0;
    int cur_load = 0;
    int rnd_m = 0;
    int sc_m = 0;

    // board model variables
    bit hit_en = 0;
    int since = 100;
    int backlog = 0;
    int pops = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] pat(input logic [15:0] v);
        if (v[4:0] == 5'd0) return 5'd4;
        return v[4:0];
    endfunction

    // Game-level reference: decides when each load should
    // appear and what score/round/status the display shows.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            phase = 0;
            rnd_m = 0;
            sc_m = 0;
            expq.delete();
        end else begin
            if ((phase == 0 || phase == 3) && bus.start) begin
                expq.push_back('{cyc + 1, pat(seq[cyc])});
                cur_load = cyc + 1;
                rnd_m = 0;
                sc_m = 0;
                phase = 1;
            end else begin
                if ((phase == 1 || phase == 2) &&
                    bus.score_trigger && sc_m < SMAX)
                    sc_m++;
                if (phase == 2) begin
                    phase = 3;
                end else if (phase == 1 && cyc > cur_load &&
                             (cyc == cur_load + MC ||
                              bus.board_state == 5'd0)) begin
                    if (rnd_m == GR - 1) begin
                        expq.push_back('{cyc + 1, 5'd0});
                        phase = 2;
                    end else begin
                        rnd_m++;
                        expq.push_back('{cyc + 1, pat(seq[cyc])});
                        cur_load = cyc + 1;
                    end
                end
            end
            cyc++;
        end
    end

    // Board-state register model with optional player who
    // whacks every mole one cycle after they appear.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.board_state <= 5'd0;
            trig_hit <= 1'b0;
            backlog = 0;
            since = 100;
        end else begin
            if (bus.load) begin
                bus.board_state <= bus.loadval;
                since = 0;
            end else begin
                if (hit_en && since == 0) begin
                    backlog += $countones(bus.board_state);
                    pops += $countones(bus.board_state);
                    bus.board_state <= 5'd0;
                end
                since++;
            end
            trig_hit <= (backlog > 0);
            if (backlog > 0) backlog--;
        end
    end

    // Monitor: scoreboard pops on load, status checked each cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc < NSEQ)
                check("lfsr", dut.u_lfsr.q, seq[cyc]);
            if (bus.load) begin
                ld_cyc.push_back(cyc);
                if (expq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL load_unexpected: load=1 val=%0d expected no load at cycle %0d",
                             bus.loadval, cyc);
                end else begin
                    ld_t e;
                    e = expq.pop_front();
                    check("load_cycle", cyc, e.cyc);
                    check("loadval", bus.loadval, e.val);
                end
            end else begin
                check("loadval_idle", bus.loadval, 0);
                if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                    checks++;
                    fails++;
                    $display("FAIL load_missing: got load=0 expected load at cycle %0d",
                             expq[0].cyc);
                    void'(expq.pop_front());
                end
            end
            check("score", bus.score, sc_m);
            check("round", bus.round, rnd_m);
            check("playing", bus.playing, phase == 1 || phase == 2);
            check("game_over", bus.game_over, phase == 3);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_over(input int budget);
        int k;
        k = 0;
        while (!bus.game_over && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("game_over_timeout", bus.game_over, 1);
    endtask

    task automatic wait_load(input int budget);
        int k;
        k = 0;
        while (!bus.load && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("load_timeout", bus.load, 1);
    endtask

    task automatic check_gaps(input int first, input int gap);
        if (ld_cyc.size() < first + 4) begin
            checks++;
            fails++;
            $display("FAIL load_count: got %0d expected %0d",
                     ld_cyc.size() - first, 4);
        end else begin
            for (int i = 0; i < 3; i++)
                check("load_gap",
                      ld_cyc[first+i+1] - ld_cyc[first+i], gap);
        end
    endtask

    initial begin
        int n0;
        int c;
        logic [15:0] v;
        v = 16'hACE1;
        for (int i = 0; i < NSEQ; i++) begin
            seq[i] = v;
            v = {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
        end
        bus.start = 1'b0;

        // reset, then idle with no start
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("idle_no_load", ld_cyc.size(), 0);
        check("idle_score", bus.score, 0);
        check("idle_over", bus.game_over, 0);

        // one game, no hits: timeout rounds
        tick($urandom_range(1, 40));
        n0 = ld_cyc.size();
        pulse_start();
        wait_over(200);
        check("nohit_round", bus.round, GR - 1);
        check("nohit_score", bus.score, 0);
        check("nohit_loads", ld_cyc.size() - n0, 4);
        check_gaps(n0, MC + 1);

        // start timed so the LFSR low bits are zero
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        c = 3;
        while (c < NSEQ - 1 && seq[c][4:0] != 5'd0) c++;
        while (cyc < c) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_load(5);
        check("fallback", bus.loadval, 5'b00100);
        wait_over(200);

        // player clears every pattern early
        tick(3);
        hit_en = 1;
        pops = 0;
        n0 = ld_cyc.size();
        pulse_start();
        wait_over(200);
        check_gaps(n0, 3);
        tick(1);
        if (backlog == 0)
            check("hit_score", bus.score, pops < SMAX ? pops : SMAX);
        hit_en = 0;
        tick(20);

        // random games mixing timeouts and early clears
        repeat (4) begin
            hit_en = ($urandom_range(0, 1) == 1);
            tick($urandom_range(1, 30));
            pulse_start();
            wait_over(200);
        end
        hit_en = 0;
        tick(20);

        // saturation, then restart clears despite a trigger
        pulse_start();
        tick(3);
        trig_man = 1'b1;
        tick(20);
        trig_man = 1'b0;
        check("saturate", bus.score, SMAX);
        wait_over(200);
        bus.start = 1'b1;
        trig_man = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        trig_man = 1'b0;
        check("clear_wins", bus.score, 0);
        wait_over(200);

        // asynchronous reset during a load cycle
        pulse_start();
        wait_load(5);
        tick(1);
        n0 = 0;
        while (!bus.load && n0 < 20) begin
            @(posedge clk);
            #1;
            n0++;
        end
        check("rst_at_load", bus.load, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_load", bus.load, 0);
        check("rst_loadval", bus.loadval, 0);
        check("rst_score", bus.score, 0);
        check("rst_round", bus.round, 0);
        check("rst_playing", bus.playing, 0);
        check("rst_over", bus.game_over, 0);
        check("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        pulse_start();
        wait_load(5);
        check("fresh_round", bus.round, 0);
        wait_over(200);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
